// File: rtl/posl_adder_pkg.sv
// Shared types and parameter checks for the sequential slice adder.
package posl_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } adder_state_t;

  // K must be a non-zero divisor of W so that W/K slices tile the operand exactly.
  function automatic bit k_w_legal(input int unsigned w, input int unsigned k);
    return (k >= 1) && (k <= w) && ((w % k) == 0);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the ripple slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/posl_slice_adder.sv
// Combinational K-bit ripple adder; also exposes the carry into its top bit.
module posl_slice_adder #(
  parameter int unsigned K = 8
) (
  input  logic [K-1:0] A,
  input  logic [K-1:0] B,
  input  logic         C_in,
  output logic [K-1:0] S,
  output logic         C_out,
  output logic         C_msb
);

  logic [K:0] c;

  assign c[0] = C_in;

  for (genvar i = 0; i < K; i++) begin : g_fa
    full_adder u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .c_in (c[i]),
      .s    (S[i]),
      .c_out(c[i+1])
    );
  end

  assign C_out = c[K];
  assign C_msb = c[K-1];

endmodule

// File: rtl/posl_adder_seq.sv
// Multi-cycle W-bit adder/subtractor reusing one K-bit ripple slice over N=W/K cycles.
module posl_adder_seq
  import posl_adder_pkg::*;
#(
  parameter int unsigned W = 128,
  parameter int unsigned K = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         C_in,
  input  logic         SUB,
  output logic [W-1:0] S,
  output logic         C_out,
  output logic         V,
  output logic         done
);

  localparam int unsigned N  = W / K;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  if (!k_w_legal(W, K)) begin : g_bad_params
    $error("posl_adder_seq: W (%0d) must be a non-zero multiple of K (%0d)", W, K);
  end

  adder_state_t state, state_next;

  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  work;
  logic [W-1:0]  work_next;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          last;

  logic [K-1:0]  sl_s;
  logic          sl_cout;
  logic          sl_cmsb;

  posl_slice_adder #(.K(K)) u_slice (
    .A    (a_sh[K-1:0]),
    .B    (b_sh[K-1:0]),
    .C_in (carry),
    .S    (sl_s),
    .C_out(sl_cout),
    .C_msb(sl_cmsb)
  );

  // Slices enter at the top and drift down, so after N steps slice 0 sits at bit 0.
  // Written as shift/or so the K==W case needs no separate structure.
  assign work_next = (work >> K) | (W'(sl_s) << (W - K));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST_CNT) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      work  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      C_out <= 1'b0;
      V     <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_sh  <= A;
        b_sh  <= SUB ? ~B : B;
        carry <= SUB ? 1'b1 : C_in;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sh  <= a_sh >> K;
        b_sh  <= b_sh >> K;
        carry <= sl_cout;
        work  <= work_next;
        if (last) begin
          cnt   <= '0;
          S     <= work_next;
          C_out <= sl_cout;
          V     <= sl_cmsb ^ sl_cout;
          done  <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_posl_adder_seq.sv
// Directed and randomised checks of posl_adder_seq at W=8/K=2 and W=128 with K=128 and K=8.
module tb_posl_adder_seq;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       c;
    logic       v;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // W=8, K=2 instance
  logic       start8, cin8, sub8, ready8, cout8, v8, done8;
  logic [7:0] a8, b8, s8;

  posl_adder_seq #(.W(8), .K(2)) dut8 (
    .clk  (clk),
    .rst  (rst),
    .start(start8),
    .ready(ready8),
    .A    (a8),
    .B    (b8),
    .C_in (cin8),
    .SUB  (sub8),
    .S    (s8),
    .C_out(cout8),
    .V    (v8),
    .done (done8)
  );

  // W=128 instances sharing stimulus
  logic         start_w, cin_w, sub_w;
  logic [127:0] a_w, b_w;
  logic         ready_w1, cout_w1, v_w1, done_w1;
  logic         ready_w16, cout_w16, v_w16, done_w16;
  logic [127:0] s_w1, s_w16;

  posl_adder_seq #(.W(128), .K(128)) dut_w1 (
    .clk  (clk),
    .rst  (rst),
    .start(start_w),
    .ready(ready_w1),
    .A    (a_w),
    .B    (b_w),
    .C_in (cin_w),
    .SUB  (sub_w),
    .S    (s_w1),
    .C_out(cout_w1),
    .V    (v_w1),
    .done (done_w1)
  );

  posl_adder_seq #(.W(128), .K(8)) dut_w16 (
    .clk  (clk),
    .rst  (rst),
    .start(start_w),
    .ready(ready_w16),
    .A    (a_w),
    .B    (b_w),
    .C_in (cin_w),
    .SUB  (sub_w),
    .S    (s_w16),
    .C_out(cout_w16),
    .V    (v_w16),
    .done (done_w16)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic cin, input logic sub,
                     input logic [7:0] es, input logic ec, input logic ev);
    int cyc;
    int rdy_hi;
    @(negedge clk);
    chk({tag, "/ready_pre"}, 128'(ready8), 128'd1);
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~a; b8 = ~b; cin8 = ~cin; sub8 = ~sub;
    cyc = 0;
    rdy_hi = 0;
    while (done8 !== 1'b1 && cyc < 20) begin
      if (ready8 !== 1'b0) rdy_hi++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "/latency"}, 128'(cyc), 128'd4);
    chk({tag, "/ready_busy"}, 128'(rdy_hi), 128'd0);
    chk({tag, "/S"}, 128'(s8), 128'(es));
    chk({tag, "/C_out"}, 128'(cout8), 128'(ec));
    chk({tag, "/V"}, 128'(v8), 128'(ev));
    chk({tag, "/ready_done"}, 128'(ready8), 128'd1);
    @(negedge clk);
    chk({tag, "/done_pulse"}, 128'(done8), 128'd0);
  endtask

  task automatic op_w(input string tag, input logic [127:0] a, input logic [127:0] b,
                      input logic cin, input logic sub);
    logic [128:0] full;
    logic [127:0] es;
    logic         ec, ev;
    logic         got1, got16;
    int           lat1, lat16, cyc;
    logic [127:0] r1s, r16s;
    logic         r1c, r1v, r16c, r16v;
    if (sub) begin
      full = {1'b0, a} - {1'b0, b};
      es   = full[127:0];
      ec   = ~full[128];
      ev   = (a[127] != b[127]) && (es[127] != a[127]);
    end else begin
      full = {1'b0, a} + {1'b0, b} + 129'(cin);
      es   = full[127:0];
      ec   = full[128];
      ev   = (a[127] == b[127]) && (es[127] != a[127]);
    end
    got1 = 1'b0; got16 = 1'b0; lat1 = -1; lat16 = -1;
    r1s = 'x; r16s = 'x; r1c = 1'bx; r1v = 1'bx; r16c = 1'bx; r16v = 1'bx;
    @(negedge clk);
    a_w = a; b_w = b; cin_w = cin; sub_w = sub; start_w = 1'b1;
    @(negedge clk);
    start_w = 1'b0;
    a_w = ~a; b_w = ~b; cin_w = ~cin; sub_w = ~sub;
    cyc = 0;
    while (cyc < 40) begin
      if (done_w1 === 1'b1 && !got1) begin
        got1 = 1'b1; lat1 = cyc; r1s = s_w1; r1c = cout_w1; r1v = v_w1;
      end
      if (done_w16 === 1'b1 && !got16) begin
        got16 = 1'b1; lat16 = cyc; r16s = s_w16; r16c = cout_w16; r16v = v_w16;
      end
      if (got1 && got16) break;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "/k128_done"}, 128'(got1), 128'd1);
    chk({tag, "/k128_lat"}, 128'(lat1), 128'd1);
    chk({tag, "/k128_S"}, r1s, es);
    chk({tag, "/k128_C"}, 128'(r1c), 128'(ec));
    chk({tag, "/k128_V"}, 128'(r1v), 128'(ev));
    chk({tag, "/k8_done"}, 128'(got16), 128'd1);
    chk({tag, "/k8_lat"}, 128'(lat16), 128'd16);
    chk({tag, "/k8_S"}, r16s, es);
    chk({tag, "/k8_C"}, 128'(r16c), 128'(ec));
    chk({tag, "/k8_V"}, 128'(r16v), 128'(ev));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[13];
    int   cyc;
    int   held;
    int   bad;

    vecs[0]  = '{8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1};
    vecs[1]  = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[2]  = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[3]  = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[4]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[5]  = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[7]  = '{8'h20, 8'h10, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0};
    vecs[8]  = '{8'h55, 8'h55, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[10] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[11] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[12] = '{8'h3C, 8'h0F, 1'b1, 1'b0, 8'h4C, 1'b0, 1'b0};

    // Reset with start asserted: reset must win.
    rst = 1'b1;
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; sub8 = 1'b0;
    start_w = 1'b0; a_w = '0; b_w = '0; cin_w = 1'b0; sub_w = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset/ready", 128'(ready8), 128'd1);
    chk("reset/done", 128'(done8), 128'd0);
    chk("reset/S", 128'(s8), 128'd0);
    chk("reset/C_out", 128'(cout8), 128'd0);
    chk("reset/V", 128'(v8), 128'd0);
    chk("reset/wide_ready", 128'({ready_w1, ready_w16}), 128'd3);
    start8 = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      op8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
          vecs[i].s, vecs[i].c, vecs[i].v);
    end

    // Back-to-back: start stays high through the first op into its done cycle.
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; sub8 = 1'b1;
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b/first_latency", 128'(cyc), 128'd4);
    chk("b2b/first_S", 128'(s8), 128'h8D);
    @(negedge clk);
    start8 = 1'b0;
    chk("b2b/second_accepted", 128'(ready8), 128'd0);
    cyc = 0;
    held = 1;
    while (done8 !== 1'b1 && cyc < 20) begin
      if (s8 !== 8'h8D) held = 0;
      @(negedge clk);
      cyc++;
    end
    chk("b2b/second_latency", 128'(cyc), 128'd4);
    chk("b2b/S_held", 128'(held), 128'd1);
    chk("b2b/second_S", 128'(s8), 128'hF0);
    chk("b2b/second_C", 128'(cout8), 128'd0);
    chk("b2b/second_V", 128'(v8), 128'd0);

    // Start pulsed mid-run with other operands must be ignored.
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'h0F; cin8 = 1'b1; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; sub8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 2;
    while (done8 !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("ignore/latency", 128'(cyc), 128'd4);
    chk("ignore/S", 128'(s8), 128'h4C);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (done8 !== 1'b0 || ready8 !== 1'b1) bad++;
    end
    chk("ignore/no_queued_op", 128'(bad), 128'd0);

    // Reset in the middle of a run abandons it.
    op8("pre_rst", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst/ready", 128'(ready8), 128'd1);
    chk("midrst/done", 128'(done8), 128'd0);
    chk("midrst/S", 128'(s8), 128'd0);
    chk("midrst/C_out", 128'(cout8), 128'd0);
    chk("midrst/V", 128'(v8), 128'd0);
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (done8 !== 1'b0) bad++;
    end
    chk("midrst/no_done", 128'(bad), 128'd0);

    // Wide configurations: corners then random operations.
    op_w("w_ones_plus1", '1, 128'd1, 1'b0, 1'b0);
    op_w("w_ones_cin", '1, '1, 1'b1, 1'b0);
    op_w("w_a_minus_a", 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
         128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b1, 1'b1);
    op_w("w_zero_minus_1", '0, 128'd1, 1'b0, 1'b1);
    op_w("w_min_minus_1", {1'b1, 127'd0}, 128'd1, 1'b0, 1'b1);
    op_w("w_max_plus_1", {1'b0, {127{1'b1}}}, 128'd1, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      op_w($sformatf("rnd%0d", i),
           {$urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom},
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
